// File: rtl/cv32e40x_pkg.sv
// ----------------------------------------------------------------------------
// cv32e40x_pkg
// Shared types for the core data-side OBI path.
//   obi_data_req_t  : request channel payload (addr, we, be, wdata, memtype,
//                     prot, atop)
//   obi_data_resp_t : response channel payload (rdata, err, exokay)
//   lsu_arb_state_e : state of the LSU/XIF data bus arbiter
// ----------------------------------------------------------------------------
package cv32e40x_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
    logic [2:0]  prot;
    logic [5:0]  atop;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        exokay;
  } obi_data_resp_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lsu_arb_state_e;

endpackage

// File: rtl/cv32e40x_lsu_arb_id_fifo.sv
// ----------------------------------------------------------------------------
// cv32e40x_lsu_arb_id_fifo
// In-order owner FIFO: one bit per outstanding bus transfer recording which
// requester (0 = LSU, 1 = XIF) issued it.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : store push_data at the tail (ignored when full)
//   push_data  : owner id of the accepted transfer
//   pop        : drop the head entry (ignored when empty)
//   head       : owner id of the oldest outstanding transfer
//   empty/full : occupancy flags
//   cnt        : number of valid entries (0..DEPTH)
// ----------------------------------------------------------------------------
module cv32e40x_lsu_arb_id_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_data,
  input  logic                         pop,
  output logic                         head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign empty     = (cnt_r == {CNT_W{1'b0}});
  assign full      = (cnt_r == CNT_W'(DEPTH));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rptr_r];
  assign cnt       = cnt_r;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r  <= {DEPTH{1'b0}};
      wptr_r <= {PTR_W{1'b0}};
      rptr_r <= {PTR_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= push_data;
        wptr_r        <= ptr_inc(wptr_r);
      end
      if (pop_ok_s) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40x_lsu_bus_arbiter.sv
// ----------------------------------------------------------------------------
// cv32e40x_lsu_bus_arbiter
// Shares the core data OBI bus between the LSU (port 0, after the response
// filter) and the XIF memory interface (port 1). A request that is waiting
// for gnt locks the arbiter onto its owner so the bus payload stays stable.
// Every accepted transfer's owner goes into an in-order ID FIFO, and each
// response is steered back combinationally to the owner at the FIFO head.
//   clk, rst_n            : clock, asynchronous active-low reset
//   m0_* / m1_*           : requester-side OBI (req/trans/gnt/rvalid/resp)
//   bus_req_o/bus_trans_o : muxed OBI request towards memory
//   bus_gnt_i/bus_rvalid_i/bus_resp_i : OBI handshake and response
//   busy_o                : transfers outstanding or a request pending
// ----------------------------------------------------------------------------
module cv32e40x_lsu_bus_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           m0_req_i,
  input  obi_data_req_t  m0_trans_i,
  output logic           m0_gnt_o,
  output logic           m0_rvalid_o,
  output obi_data_resp_t m0_resp_o,
  input  logic           m1_req_i,
  input  obi_data_req_t  m1_trans_i,
  output logic           m1_gnt_o,
  output logic           m1_rvalid_o,
  output obi_data_resp_t m1_resp_o,
  output logic           bus_req_o,
  output obi_data_req_t  bus_trans_o,
  input  logic           bus_gnt_i,
  input  logic           bus_rvalid_i,
  input  obi_data_resp_t bus_resp_i,
  output logic           busy_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  lsu_arb_state_e   state_r;
  logic             lock_owner_r;
  logic             last_grant_r;
  logic             sel_s;
  logic             eligible_s;
  logic             accept_s;
  logic             fifo_head_s;
  logic             fifo_empty_s;
  logic             fifo_full_s;
  logic [CNT_W-1:0] fifo_cnt_s;

  // Eligibility uses the registered count only, so the req path never depends
  // on bus_rvalid_i; a response at cnt == DEPTH frees the slot one cycle later.
  assign eligible_s = (fifo_cnt_s < CNT_W'(DEPTH));

  // Select the requester that drives the bus this cycle.
  always_comb begin
    sel_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (m0_req_i && m1_req_i) begin
          sel_s = !last_grant_r;
        end else if (m1_req_i) begin
          sel_s = 1'b1;
        end else begin
          sel_s = 1'b0;
        end
      end
      ARB_LOCKED: sel_s = lock_owner_r;
      default:    sel_s = 1'b0;
    endcase
  end

  assign bus_req_o   = eligible_s && (sel_s ? m1_req_i : m0_req_i);
  assign bus_trans_o = sel_s ? m1_trans_i : m0_trans_i;
  assign accept_s    = bus_req_o && bus_gnt_i;
  assign m0_gnt_o    = accept_s && !sel_s;
  assign m1_gnt_o    = accept_s && sel_s;

  // A response with an empty FIFO belongs to no live transfer and is dropped.
  assign m0_rvalid_o = bus_rvalid_i && !fifo_empty_s && !fifo_head_s;
  assign m1_rvalid_o = bus_rvalid_i && !fifo_empty_s && fifo_head_s;
  assign m0_resp_o   = bus_resp_i;
  assign m1_resp_o   = bus_resp_i;

  assign busy_o = (fifo_cnt_s != {CNT_W{1'b0}}) || m0_req_i || m1_req_i;

  // Grant lock while a request waits on gnt, plus round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      lock_owner_r <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (bus_req_o && !bus_gnt_i) begin
            state_r      <= ARB_LOCKED;
            lock_owner_r <= sel_s;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_LOCKED: begin
          if (bus_gnt_i) begin
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_LOCKED;
          end
        end
        default: state_r <= ARB_IDLE;
      endcase
      if (accept_s) begin
        last_grant_r <= sel_s;
      end
    end
  end

  cv32e40x_lsu_arb_id_fifo #(
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept_s),
    .push_data (sel_s),
    .pop       (bus_rvalid_i),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .cnt       (fifo_cnt_s)
  );

  cv32e40x_lsu_bus_arbiter_checker u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .locked     (state_r == ARB_LOCKED),
    .lock_owner (lock_owner_r),
    .m0_req     (m0_req_i),
    .m1_req     (m1_req_i),
    .push       (accept_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .rvalid     (bus_rvalid_i)
  );

endmodule

// ----------------------------------------------------------------------------
// cv32e40x_lsu_bus_arbiter_checker
// Protocol properties of the arbiter; no functional outputs.
//   locked/lock_owner : arbiter holds a grant for this requester
//   m0_req/m1_req     : requester reqs
//   push/full/empty   : ID FIFO handshake and flags
//   rvalid            : bus response valid
// ----------------------------------------------------------------------------
module cv32e40x_lsu_bus_arbiter_checker (
  input logic clk,
  input logic rst_n,
  input logic locked,
  input logic lock_owner,
  input logic m0_req,
  input logic m1_req,
  input logic push,
  input logic full,
  input logic empty,
  input logic rvalid
);

  logic active_r;

  // Responses of transfers issued before a reset may still arrive; a stray
  // response only indicates an error once a transfer has been issued since.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
    end else if (push) begin
      active_r <= 1'b1;
    end else begin
      active_r <= active_r;
    end
  end

  a_req_held_while_locked : assert property (@(posedge clk) disable iff (!rst_n)
    locked |-> (lock_owner ? m1_req : m0_req));

  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full));

  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(rvalid && empty && active_r));

endmodule

// File: tb/tb_cv32e40x_lsu_bus_arbiter.sv
module tb_cv32e40x_lsu_bus_arbiter;
  import cv32e40x_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           m0_req, m1_req;
  obi_data_req_t  m0_trans, m1_trans;
  logic           m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  obi_data_resp_t m0_resp, m1_resp;
  logic           bus_req;
  obi_data_req_t  bus_trans;
  logic           bus_gnt, bus_rvalid;
  obi_data_resp_t bus_resp;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40x_lsu_bus_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_trans_i(m0_trans), .m0_gnt_o(m0_gnt),
    .m0_rvalid_o(m0_rvalid), .m0_resp_o(m0_resp),
    .m1_req_i(m1_req), .m1_trans_i(m1_trans), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_resp_o(m1_resp),
    .bus_req_o(bus_req), .bus_trans_o(bus_trans), .bus_gnt_i(bus_gnt),
    .bus_rvalid_i(bus_rvalid), .bus_resp_i(bus_resp), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obi_data_req_t mk_trans(input logic [31:0] addr);
    obi_data_req_t t;
    t = '0;
    t.addr  = addr;
    t.be    = 4'hF;
    t.wdata = ~addr;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    bus_resp = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    m0_trans = mk_trans(32'h0000_0040);
    m1_trans = mk_trans(32'h0000_0080);
    #2;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b exp 0", bus_req); end
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b exp 00", {m0_gnt, m1_gnt}); end
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (bus_trans.addr !== 32'h0000_0040) begin n_fail++; $display("FAIL reset_trans_default: got %h exp 00000040", bus_trans.addr); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_load();
    m0_req = 1'b1; m0_trans = mk_trans(32'h0000_1000); bus_gnt = 1'b1;
    #2;
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL single_gnt: got %b exp 10", {m0_gnt, m1_gnt}); end
    n_checks++; if (bus_trans.addr !== 32'h0000_1000) begin n_fail++; $display("FAIL single_addr: got %h exp 00001000", bus_trans.addr); end
    step();
    m0_req = 1'b0; bus_gnt = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_outstanding: got %b exp 1", busy); end
    step();
    bus_rvalid = 1'b1; bus_resp.rdata = 32'hDEAD_BEEF;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL single_rvalid: got %b exp 10", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (m0_resp.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h exp deadbeef", m0_resp.rdata); end
    step();
    idle_inputs();
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b exp 0", busy); end
    step();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m0_trans = mk_trans(32'h0000_1000);
    m1_trans = mk_trans(32'h0000_2000);
    for (int k = 0; k < 5; k++) begin
      m0_req = (k < 4); m1_req = (k < 4); bus_gnt = (k < 4);
      bus_rvalid = (k >= 1); bus_resp.rdata = 32'(k);
      #2;
      if (k < 4) begin
        n_checks++; if (m0_gnt !== (k % 2 == 0)) begin n_fail++; $display("FAIL rr_m0_gnt k=%0d: got %b exp %b", k, m0_gnt, (k % 2 == 0)); end
        n_checks++; if (m1_gnt !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_m1_gnt k=%0d: got %b exp %b", k, m1_gnt, (k % 2 == 1)); end
        n_checks++; if (bus_trans.addr !== ((k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000)) begin n_fail++; $display("FAIL rr_addr k=%0d: got %h", k, bus_trans.addr); end
      end else begin
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL rr_gnt_end: got %b exp 00", {m0_gnt, m1_gnt}); end
      end
      if (k >= 1) begin
        n_checks++; if (m0_rvalid !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_m0_rvalid k=%0d: got %b exp %b", k, m0_rvalid, (k % 2 == 1)); end
        n_checks++; if (m1_rvalid !== (k % 2 == 0)) begin n_fail++; $display("FAIL rr_m1_rvalid k=%0d: got %b exp %b", k, m1_rvalid, (k % 2 == 0)); end
        n_checks++; if (((k % 2 == 1) ? m0_resp.rdata : m1_resp.rdata) !== 32'(k)) begin n_fail++; $display("FAIL rr_rdata k=%0d: got %h exp %h", k, ((k % 2 == 1) ? m0_resp.rdata : m1_resp.rdata), k); end
      end
      step();
    end
    idle_inputs();
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_end: got %b exp 0", busy); end
    step();
  endtask

  task automatic test_lock();
    m0_trans = mk_trans(32'h0000_0100);
    m1_trans = mk_trans(32'h0000_0200);
    for (int c = 0; c < 4; c++) begin
      m0_req = 1'b1; m1_req = (c >= 1); bus_gnt = (c == 3);
      #2;
      n_checks++; if (bus_trans.addr !== 32'h0000_0100) begin n_fail++; $display("FAIL lock_addr c=%0d: got %h exp 00000100", c, bus_trans.addr); end
      n_checks++; if ({m0_gnt, m1_gnt} !== ((c == 3) ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL lock_gnt c=%0d: got %b", c, {m0_gnt, m1_gnt}); end
      step();
    end
    m0_req = 1'b0; m1_req = 1'b1; bus_gnt = 1'b1;
    #2;
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL lock_m1_next: got %b exp 01", {m0_gnt, m1_gnt}); end
    n_checks++; if (bus_trans.addr !== 32'h0000_0200) begin n_fail++; $display("FAIL lock_m1_addr: got %h exp 00000200", bus_trans.addr); end
    step();
    idle_inputs(); bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_000A;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL lock_resp0: got %b exp 10", {m0_rvalid, m1_rvalid}); end
    step();
    bus_resp.rdata = 32'h0000_000B;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL lock_resp1: got %b exp 01", {m0_rvalid, m1_rvalid}); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_depth_gating();
    m0_req = 1'b1; bus_gnt = 1'b1;
    #2;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL depth_acc1: got %b exp 1", m0_gnt); end
    step();
    #2;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL depth_acc2: got %b exp 1", m0_gnt); end
    step();
    m0_req = 1'b0; m1_req = 1'b1; bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_0011;
    #2;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL depth_full_req: got %b exp 0", bus_req); end
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL depth_full_gnt: got %b exp 00", {m0_gnt, m1_gnt}); end
    n_checks++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL depth_full_rvalid: got %b exp 1", m0_rvalid); end
    step();
    bus_rvalid = 1'b0;
    #2;
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL depth_freed_req: got %b exp 1", bus_req); end
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL depth_freed_gnt: got %b exp 1", m1_gnt); end
    step();
    idle_inputs(); bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_0012;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL depth_drain0: got %b exp 10", {m0_rvalid, m1_rvalid}); end
    step();
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL depth_drain1: got %b exp 01", {m0_rvalid, m1_rvalid}); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_push_pop();
    m1_req = 1'b1; bus_gnt = 1'b1;
    step();
    m1_req = 1'b0; m0_req = 1'b1; bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_0021;
    #2;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL pp_gnt: got %b exp 1", m0_gnt); end
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL pp_old_owner: got %b exp 01", {m0_rvalid, m1_rvalid}); end
    n_checks++; if (m1_resp.rdata !== 32'h0000_0021) begin n_fail++; $display("FAIL pp_rdata: got %h exp 00000021", m1_resp.rdata); end
    step();
    m0_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pp_cnt_held: got %b exp 1", busy); end
    step();
    bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_0022;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL pp_new_owner: got %b exp 10", {m0_rvalid, m1_rvalid}); end
    step();
    idle_inputs();
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pp_busy_end: got %b exp 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; bus_gnt = 1'b1;
    step();
    m0_req = 1'b0; m1_req = 1'b1;
    step();
    idle_inputs();
    #2;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_cleared: got %b exp 0", busy); end
    step();
    rst_n = 1'b1;
    step();
    bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_0033;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_stray: got %b exp 00", {m0_rvalid, m1_rvalid}); end
    step();
    bus_rvalid = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_cnt: got %b exp 0", busy); end
    m1_req = 1'b1; bus_gnt = 1'b1;
    #1;
    n_checks++; if ({bus_req, m1_gnt} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_next_req: got %b exp 11", {bus_req, m1_gnt}); end
    step();
    idle_inputs(); bus_rvalid = 1'b1; bus_resp.rdata = 32'h0000_0055;
    #2;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_next_resp: got %b exp 01", {m0_rvalid, m1_rvalid}); end
    step();
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_lock();
    test_depth_gating();
    test_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cv32e40x_lsu_bus_arbiter.md
Name: cv32e40x_lsu_bus_arbiter

Overview:
- Shares the single OBI data bus between two data requesters: port 0 is the LSU (post response filter) and port 1 is the XIF memory interface.
- Arbitrates requests and holds a grant stable while a request waits on the bus.
- Tracks the owner of every outstanding transfer in an in-order ID FIFO, and steers each bus response back to the owning requester.
- Sits between the LSU response filter and the core data OBI ports.

Parameters:
DEPTH, 2, maximum outstanding bus transfers across both requesters (must be >= 1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
m0_req_i  input  1  LSU request
m0_trans_i  input  obi_data_req_t  LSU transfer (addr, we, be, wdata, memtype, prot, atop)
m0_gnt_o  output  1  LSU grant
m0_rvalid_o  output  1  LSU response valid
m0_resp_o  output  obi_data_resp_t  LSU response (rdata, err, exokay)
m1_req_i  input  1  XIF memory request
m1_trans_i  input  obi_data_req_t  XIF transfer
m1_gnt_o  output  1  XIF grant
m1_rvalid_o  output  1  XIF response valid
m1_resp_o  output  obi_data_resp_t  XIF response
bus_req_o  output  1  OBI req to memory
bus_trans_o  output  obi_data_req_t  muxed transfer
bus_gnt_i  input  1  OBI gnt
bus_rvalid_i  input  1  OBI rvalid
bus_resp_i  input  obi_data_resp_t  OBI response
busy_o  output  1  outstanding count != 0, or any req pending

Behaviour:
- Reset (async, rst_n low):
  - state IDLE, lock_owner 0, last_grant 1 (so port 0 wins the first tie), cnt 0, ID FIFO empty.
  - All outputs are combinational and evaluate to 0 at reset with idle inputs.
- Request gating: eligible = cnt < DEPTH. When not eligible, bus_req_o = 0 and both gnts = 0.
- State machine:
  - IDLE: sel = sole requester if only one req is high. If both are high, sel = !last_grant (round-robin). No req: no transfer.
  - IDLE -> LOCKED when bus_req_o && !bus_gnt_i; lock_owner <= sel.
  - LOCKED: sel = lock_owner; the other requester is ignored. bus_trans_o must stay stable, per the OBI rule.
  - LOCKED -> IDLE on bus_gnt_i.
- A requester dropping req before gnt is a protocol violation: assertion only, no recovery.
- Outputs:
  - bus_req_o = eligible && req[sel].
  - bus_trans_o = trans[sel]; when idle, defaults to m0_trans_i.
  - gnt[sel] = bus_gnt_i && bus_req_o; the other gnt = 0.
- Accept = bus_req_o && bus_gnt_i. On accept: last_grant <= sel, push sel into the ID FIFO, cnt++.
- ID FIFO:
  - DEPTH entries of 1 bit, with read/write pointers that wrap modulo DEPTH.
  - Pop on bus_rvalid_i; cnt-- on pop.
  - Push and pop in the same cycle: cnt unchanged, both pointers advance.
  - Push with cnt == DEPTH is impossible by gating; assert it never happens.
- Response routing is zero-latency combinational:
  - m0_rvalid_o = bus_rvalid_i && head == 0; m1_rvalid_o = bus_rvalid_i && head == 1.
  - Both m*_resp_o = bus_resp_i, unqualified.
- bus_rvalid_i with an empty FIFO is dropped (no rvalid out) and flagged by an assertion.
- Response in the same cycle as a new accept at cnt == DEPTH:
  - The accept is not allowed, because eligibility uses the registered cnt.
  - This costs one cycle of bandwidth; it keeps the req path free of combinational dependency on rvalid.
- Reset mid-operation clears cnt and the FIFO. Responses still in flight after reset are dropped per the empty-FIFO rule.
- cnt width: $clog2(DEPTH+1). Pointer width: max(1, $clog2(DEPTH)).

Decomposition:
- Shared package (cv32e40x_pkg): obi_data_req_t and obi_data_resp_t (existing); a new enum lsu_arb_state_e {ARB_IDLE, ARB_LOCKED}.
- One sub-module, cv32e40x_lsu_arb_id_fifo: 1-bit wide, DEPTH deep, with push, pop, head, empty, full and cnt outputs.

Test Plan:
- Single LSU load, gnt same cycle, rvalid 2 cycles later -> m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 in cycle 2 with rdata 0xDEADBEEF; m1 outputs stay 0; busy_o falls after the response.
- Both req high every cycle, gnt always 1 -> grants alternate m0, m1, m0, m1. Responses return in order: m0 rdata 0x1, m1 rdata 0x2, and so on.
- m0 req, gnt withheld 3 cycles, m1 req raised in cycle 1 -> LOCKED on m0; bus_trans_o keeps m0 addr 0x100 for all 4 cycles; m0 granted in cycle 3; m1 granted next.
- DEPTH=2: two accepts, no rvalid -> third req sees bus_req_o=0 and gnt=0. One rvalid -> next cycle, bus_req_o=1 and grant is allowed.
- Simultaneous accept and rvalid at cnt=1 -> cnt stays 1, FIFO head advances, and the response goes to the older owner.
- Assert rst_n low with 2 outstanding, release, then inject a stray rvalid -> no m*_rvalid_o, cnt=0, and the next request proceeds normally.
